bvudiv_slt_inv_search: RTL and testbench

- Sequential controller that finds a witness x such that (x udiv s) <s t, where x is the dividend and the comparison is signed, for given WIDTH-bit s and t.
- Owns one shared bit-serial restoring divider and schedules it across candidates x = 0, 1, 2, … in ascending order.
- Reports the first satisfying x, or that no solution exists.
- Used as a hardware cross-check for the combinational invertibility/Skolem blocks of the same bvslt/bvudiv condition.

---
 rtl/bvudiv_slt_inv_search.sv | 183 ++++++++++++++++++
 tb/tb_bvudiv_slt_inv_search.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bvudiv_slt_inv_search.sv
`default_nettype none
// ============================================================================
// Module   : bvudiv_slt_inv_search
// Purpose  : Sequential witness search for (x udiv s) <s t. Candidates
//            x = 0, 1, 2, ... are fed one at a time through a single shared
//            bit-serial restoring divider. The first x whose quotient is
//            signed-less-than t is reported; if every x fails, found=0.
//            Used to cross-check combinational invertibility/Skolem logic
//            for the same bvslt/bvudiv condition.
// Ports    : clk          - system clock, rising edge
//            rst_n        - asynchronous active-low reset
//            start_valid  - request valid (s, t sampled on handshake)
//            start_ready  - high only while idle
//            s            - divisor operand (WIDTH bits)
//            t            - signed comparison bound (WIDTH bits)
//            done_valid   - result valid, held until done_ready
//            done_ready   - result accept
//            found        - 1: x is a witness, 0: no witness exists
//            x            - witness value (0 when found=0)
//            busy         - high in every state except idle
// Revision : 1.0 - initial release
// ============================================================================
module bvudiv_slt_inv_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] t,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             found,
  output logic [WIDTH-1:0] x,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH) + 1;

  localparam logic [SW-1:0]    LAST_STEP = SW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] CAND_MAX  = {WIDTH{1'b1}};

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_DIV   = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;

  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_t;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [SW-1:0]    r_step;
  logic             r_found;
  logic [WIDTH-1:0] r_x;

  logic             w_start;
  logic [WIDTH:0]   w_shift_rem;
  logic             w_ge;
  logic [WIDTH:0]   w_sub;
  logic             w_lt;
  logic             w_last_step;
  logic             w_last_cand;

  assign w_start     = start_valid && (r_state == ST_IDLE);
  assign w_last_step = (r_step == LAST_STEP);
  assign w_last_cand = (r_cand == CAND_MAX);

  // One restoring step: shift the next dividend bit into the remainder.
  // r_rem[WIDTH] is the bit shifted out of the top; if it is ever set the
  // true shifted value exceeds any WIDTH-bit divisor, so it forces "ge".
  // With s=0 every step subtracts nothing and sets the quotient bit, which
  // produces the all-ones udiv-by-zero result without a special case.
  assign w_shift_rem = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_ge        = r_rem[WIDTH] || (w_shift_rem >= {1'b0, r_s});
  assign w_sub       = w_shift_rem - {1'b0, r_s};

  assign w_lt = $signed(r_quo) < $signed(r_t);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_next_state = ST_LOAD;
      ST_LOAD:  w_next_state = ST_DIV;
      ST_DIV:   if (w_last_step) w_next_state = ST_CHECK;
      ST_CHECK: begin
        if (w_lt || w_last_cand) w_next_state = ST_DONE;
        else                     w_next_state = ST_LOAD;
      end
      ST_DONE:  if (done_ready) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    start_ready = 1'b0;
    busy        = 1'b1;
    done_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      ST_DONE: done_valid = 1'b1;
      default: ;
    endcase
  end

  assign found = r_found;
  assign x     = r_x;

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s     <= '0;
      r_t     <= '0;
      r_cand  <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_step  <= '0;
      r_found <= 1'b0;
      r_x     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_s     <= s;
            r_t     <= t;
            r_cand  <= '0;
            // Old result is dropped so nothing stale is visible mid-search.
            r_found <= 1'b0;
            r_x     <= '0;
          end
        end
        ST_LOAD: begin
          r_rem  <= '0;
          r_quo  <= r_cand;
          r_step <= '0;
        end
        ST_DIV: begin
          if (w_ge) begin
            r_rem <= w_sub;
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_shift_rem;
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
          r_step <= r_step + 1'b1;
        end
        ST_CHECK: begin
          if (w_lt) begin
            r_x     <= r_cand;
            r_found <= 1'b1;
          end else if (w_last_cand) begin
            r_x     <= '0;
            r_found <= 1'b0;
          end else begin
            r_cand <= r_cand + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bvudiv_slt_inv_search.sv
`default_nettype none
// ============================================================================
// Module   : tb_bvudiv_slt_inv_search
// Purpose  : Directed self-checking bench for bvudiv_slt_inv_search with
//            WIDTH=4: reset values, search results and latencies, the
//            udiv-by-zero path, no-solution exhaustion, result backpressure
//            and an asynchronous reset in the middle of a search.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bvudiv_slt_inv_search;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] t;
  logic             done_valid;
  logic             done_ready;
  logic             found;
  logic [WIDTH-1:0] x;
  logic             busy;

  int errors = 0;
  int checks = 0;

  bvudiv_slt_inv_search #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .s           (s),
    .t           (t),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .found       (found),
    .x           (x),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request and let it be taken on the next rising edge.
  // Returns ok=0 if start_ready never appeared.
  task automatic do_start(input logic [WIDTH-1:0] s_in, input logic [WIDTH-1:0] t_in,
                          output bit ok);
    int n;
    n = 0;
    while (start_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (start_ready === 1'b1);
    s = s_in;
    t = t_in;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  // Counts rising edges after the accepting edge until done_valid is seen.
  task automatic wait_done(output int edges);
    edges = 1;
    #0;
    edges = 0;
    while (edges < 300) begin
      if (edges > 0 && done_valid === 1'b1) break;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic accept_done();
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({start_ready, busy, done_valid, found, x} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b busy=%b dv=%b found=%b x=%h want rdy=1 busy=0 dv=0 found=0 x=0",
               start_ready, busy, done_valid, found, x);
    end
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got rdy=%b busy=%b want rdy=1 busy=0", start_ready, busy);
    end
  endtask

  task automatic test_search_vectors();
    // {s, t, found, x, edges}
    logic [WIDTH-1:0] vs [5] = '{4'h1, 4'h0, 4'h1, 4'h2, 4'h3};
    logic [WIDTH-1:0] vt [5] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h8};
    logic             vf [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [WIDTH-1:0] vx [5] = '{4'h0, 4'h0, 4'h8, 4'h0, 4'h0};
    int               ve [5] = '{6, 6, 54, 96, 96};
    bit ok;
    int edges;
    for (int i = 0; i < 5; i++) begin
      do_start(vs[i], vt[i], ok);
      checks++;
      if (!ok || busy !== 1'b1 || start_ready !== 1'b0) begin
        errors++;
        $display("FAIL search%0d_accept: got ok=%b busy=%b rdy=%b want ok=1 busy=1 rdy=0",
                 i, ok, busy, start_ready);
      end
      wait_done(edges);
      checks++;
      if (edges !== ve[i]) begin
        errors++;
        $display("FAIL search%0d_latency: got %0d edges want %0d", i, edges, ve[i]);
      end
      checks++;
      if (done_valid !== 1'b1 || found !== vf[i] || x !== vx[i]) begin
        errors++;
        $display("FAIL search%0d_result s=%h t=%h: got dv=%b found=%b x=%h want dv=1 found=%b x=%h",
                 i, vs[i], vt[i], done_valid, found, x, vf[i], vx[i]);
      end
      accept_done();
      checks++;
      if (done_valid !== 1'b0 || start_ready !== 1'b1) begin
        errors++;
        $display("FAIL search%0d_release: got dv=%b rdy=%b want dv=0 rdy=1", i, done_valid, start_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int edges;
    int bad;
    do_start(4'h1, 4'h1, ok);
    wait_done(edges);
    checks++;
    if (!ok || edges !== 6) begin
      errors++;
      $display("FAIL bp_latency: got ok=%b edges=%0d want ok=1 edges=6", ok, edges);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      s = 4'h2;
      t = 4'h0;
      start_valid = i[0];
      @(posedge clk); #1;
      if (done_valid !== 1'b1 || found !== 1'b1 || x !== 4'h0 || start_ready !== 1'b0) bad++;
    end
    start_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d unstable cycles want 0 (last dv=%b found=%b x=%h rdy=%b)",
               bad, done_valid, found, x, start_ready);
    end
    // start_valid held high across the accepting edge must not be taken.
    start_valid = 1'b1;
    done_ready  = 1'b1;
    @(posedge clk); #1;
    done_ready  = 1'b0;
    start_valid = 1'b0;
    checks++;
    if (done_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got dv=%b rdy=%b busy=%b want dv=0 rdy=1 busy=0",
               done_valid, start_ready, busy);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int edges;
    do_start(4'h2, 4'h0, ok);
    // Candidate 3 enters LOAD on edge 18 and is dividing after edge 20.
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (!ok || busy !== 1'b1 || done_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_busy: got ok=%b busy=%b dv=%b want ok=1 busy=1 dv=0", ok, busy, done_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({start_ready, busy, done_valid, found, x} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL midrst_outputs: got rdy=%b busy=%b dv=%b found=%b x=%h want rdy=1 busy=0 dv=0 found=0 x=0",
               start_ready, busy, done_valid, found, x);
    end
    #2;
    rst_n = 1'b1;
    do_start(4'h1, 4'h1, ok);
    wait_done(edges);
    checks++;
    if (!ok || edges !== 6 || found !== 1'b1 || x !== 4'h0) begin
      errors++;
      $display("FAIL midrst_restart: got ok=%b edges=%0d found=%b x=%h want ok=1 edges=6 found=1 x=0",
               ok, edges, found, x);
    end
    accept_done();
  endtask

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    done_ready  = 1'b0;
    s           = '0;
    t           = '0;
    test_reset();
    test_search_vectors();
    test_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
